// File: rtl/ks_pkg.sv
// ks_pkg: shared helpers for the segmented Kogge-Stone adder
package ks_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic bit legal_cfg(input int bw, input int segs);
    return segs >= 1 && segs <= 8 && bw % segs == 0;
  endfunction
endpackage

// File: rtl/ks_pipe_adder_if.sv
// ks_pipe_adder_if: operand/result stream bundle for ks_pipe_adder
interface ks_pipe_adder_if #(parameter int BW = 32);
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
  logic [BW-1:0] a, b, sum;
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input in_ready, out_valid, sum, cout, overflow
  );
  modport slave (
    input in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/ks_prefix_seg.sv
// ks_prefix_seg: combinational SW-bit Kogge-Stone carry tree with carry in
module ks_prefix_seg import ks_pkg::*; #(
  parameter int SW = 16
) (
  input logic [SW-1:0] g,
  input logic [SW-1:0] p,
  input logic cin,
  output logic [SW-1:0] sum,
  output logic cout
);
  localparam int L = clog2(SW);
  logic [SW-1:0] gg, pp, gn, pn;
  logic [SW:0] c;
  // cin is folded into bit 0 so each prefix group already includes it
  always_comb begin
    gg = g;
    gg[0] = g[0] | (p[0] & cin);
    pp = p;
    gn = gg;
    pn = pp;
    for (int l = 0; l < L; l++) begin
      gn = gg;
      pn = pp;
      for (int i = 1 << l; i < SW; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-(1<<l)]);
        pn[i] = pp[i] & pp[i-(1<<l)];
      end
      gg = gn;
      pp = pn;
    end
  end
  assign c = {gg, cin};
  assign sum = p ^ c[SW-1:0];
  assign cout = c[SW];
endmodule

// File: rtl/ks_pipe_adder.sv
// ks_pipe_adder: segment-pipelined Kogge-Stone add/sub with global-stall valid/ready
// Define KS_PIPE_OVF_EN to build the signed-overflow MSB pipeline; otherwise overflow is 0.
module ks_pipe_adder import ks_pkg::*; #(
  parameter int BW = 32,
  parameter int SEGS = 2
) (
  input logic clk,
  input logic resetn,
  ks_pipe_adder_if.slave io
);
  localparam int SW = BW / SEGS;
  localparam bit LEGAL = legal_cfg(BW, SEGS);
  if (!LEGAL) begin : g_bad
    $fatal(1, "ks_pipe_adder: BW must be a multiple of SEGS and SEGS must be 1..8");
  end
  logic adv, c0;
  logic [BW-1:0] b_eff, g_in, p_in;
  assign adv = !io.out_valid || io.out_ready;
  assign io.in_ready = adv;
  assign b_eff = io.b ^ {BW{io.sub}};
  assign c0 = io.sub | io.cin;
  assign g_in = io.a & b_eff;
  assign p_in = io.a ^ b_eff;
  for (genvar k = 0; k < SEGS; k++) begin : g_st
    localparam int RW = BW - k*SW;
    logic [RW-1:0] gx, px;
    logic [(k+1)*SW-1:0] s_d, s_q;
    logic [SW-1:0] s_seg;
    logic ci, co, vi, v_q, c_q;
`ifdef KS_PIPE_OVF_EN
    logic am_d, bm_d, am_q, bm_q;
`endif
    if (k == 0) begin : g_src
      assign gx = g_in, px = p_in, ci = c0, vi = io.in_valid, s_d = s_seg;
`ifdef KS_PIPE_OVF_EN
      assign am_d = io.a[BW-1], bm_d = b_eff[BW-1];
`endif
    end else begin : g_src
      assign gx = g_st[k-1].g_skew.g_q, px = g_st[k-1].g_skew.p_q;
      assign ci = g_st[k-1].c_q, vi = g_st[k-1].v_q, s_d = {s_seg, g_st[k-1].s_q};
`ifdef KS_PIPE_OVF_EN
      assign am_d = g_st[k-1].am_q, bm_d = g_st[k-1].bm_q;
`endif
    end
    ks_prefix_seg #(.SW(SW)) u_seg (
      .g(gx[SW-1:0]),
      .p(px[SW-1:0]),
      .cin(ci),
      .sum(s_seg),
      .cout(co)
    );
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= vi;
        c_q <= co;
        s_q <= s_d;
      end
    // unresolved upper segments wait here until their stage comes up
    if (k < SEGS-1) begin : g_skew
      logic [RW-SW-1:0] g_q, p_q;
      always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
          g_q <= '0;
          p_q <= '0;
        end else if (adv) begin
          g_q <= gx[RW-1:SW];
          p_q <= px[RW-1:SW];
        end
    end
`ifdef KS_PIPE_OVF_EN
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        am_q <= 1'b0;
        bm_q <= 1'b0;
      end else if (adv) begin
        am_q <= am_d;
        bm_q <= bm_d;
      end
`endif
  end
  assign io.out_valid = g_st[SEGS-1].v_q;
  assign io.sum = g_st[SEGS-1].s_q;
  assign io.cout = g_st[SEGS-1].c_q;
`ifdef KS_PIPE_OVF_EN
  assign io.overflow = (g_st[SEGS-1].am_q == g_st[SEGS-1].bm_q) &&
                       (g_st[SEGS-1].s_q[BW-1] != g_st[SEGS-1].am_q);
`else
  assign io.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_ks_pipe_adder.sv
// tb_ks_pipe_adder: randomized and directed checks of ks_pipe_adder against an arithmetic model
module tb_ks_pipe_adder;
  localparam int BW = 32;
  localparam int SEGS = 2;
`ifdef KS_PIPE_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;
  ks_pipe_adder_if #(.BW(BW)) io ();
  ks_pipe_adder #(.BW(BW), .SEGS(SEGS)) dut (.clk(clk), .resetn(resetn), .io(io));
  int total = 0;
  int bad = 0;
  logic [33:0] exp_q[$];
  logic [BW-1:0] outs[$];
  logic [33:0] last_out;
  logic [BW-1:0] held;
  bit got, acc, stalled;

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // {overflow, cout, sum} from plain integer arithmetic
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [32:0] r;
    longint sr;
    bit ovf;
    if (sub) begin
      r = {a >= b, a - b};
      sr = longint'($signed(a)) - longint'($signed(b));
    end else begin
      r = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      sr = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end
    ovf = OVF_ON && (sr > 64'sd2147483647 || sr < -64'sd2147483648);
    return {ovf, r};
  endfunction

  task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub, input logic ordy);
    io.in_valid = iv;
    io.a = a;
    io.b = b;
    io.cin = cin;
    io.sub = sub;
    io.out_ready = ordy;
    #1;
    acc = iv && io.in_ready;
    got = 0;
    if (resetn) begin
      check("in_ready", io.in_ready, !(io.out_valid && !ordy));
      if (stalled) begin
        check("hold_valid", io.out_valid, 1);
        check("hold_sum", io.sum, held);
      end
      if (io.out_valid && ordy) begin
        last_out = {io.overflow, io.cout, io.sum};
        got = 1;
        outs.push_back(io.sum);
        if (exp_q.size() == 0) check("spurious_out", io.out_valid, 0);
        else check("result", last_out, exp_q.pop_front());
      end
      stalled = io.out_valid && !ordy;
      held = io.sum;
      if (acc) exp_q.push_back(model(a, b, cin, sub));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic one(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic cin, input logic sub, input logic [31:0] es,
                     input logic ec, input logic eo);
    int lat;
    step(1, a, b, cin, sub, 1);
    lat = 0;
    while (!got && lat < 20) begin
      step(0, 0, 0, 0, 0, 1);
      lat++;
    end
    check({tag, "_lat"}, lat, SEGS);
    check({tag, "_sum"}, last_out[31:0], es);
    check({tag, "_cout"}, last_out[32], ec);
    check({tag, "_ovf"}, last_out[33], eo);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) step(0, 0, 0, 0, 0, 1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int i, cyc;
    logic [31:0] ra, rb;
    io.in_valid = 0;
    io.a = 0;
    io.b = 0;
    io.cin = 0;
    io.sub = 0;
    io.out_ready = 0;
    stalled = 0;
    #2 resetn = 0;
    repeat (3) @(negedge clk);
    check("rst_valid", io.out_valid, 0);
    check("rst_sum", io.sum, 0);
    check("rst_cout", io.cout, 0);
    check("rst_ovf", io.overflow, 0);
    resetn = 1;
    #1 check("rst_ready", io.in_ready, 1);
    @(negedge clk);
    one("wrap", 32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 0);
    one("seg_carry", 32'h0000_FFFF, 32'h1, 0, 0, 32'h0001_0000, 0, 0);
    one("sub", 32'd5, 32'd7, 1, 1, 32'hFFFF_FFFE, 0, 0);
    one("sub_nb", 32'd7, 32'd5, 0, 1, 32'd2, 1, 0);
    one("cin", 32'd1, 32'd2, 1, 0, 32'd4, 0, 0);
    one("ovf", 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, OVF_ON);
    drain();
    outs.delete();
    i = 1;
    cyc = 0;
    while (i <= 6 && cyc < 50) begin
      step(1, 32'(i), 32'(i), 0, 0, !(cyc >= 3 && cyc < 6));
      if (acc) i++;
      cyc++;
    end
    drain();
    check("bp_count", outs.size(), 6);
    for (int j = 0; j < 6; j++)
      if (j < outs.size()) check("bp_order", outs[j], 2 * (j + 1));
    step(1, 32'h11, 32'h22, 0, 0, 1);
    step(1, 32'h33, 32'h44, 0, 0, 1);
    resetn = 0;
    #1;
    check("rst_mid_valid", io.out_valid, 0);
    check("rst_mid_sum", io.sum, 0);
    exp_q.delete();
    stalled = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    for (int n = 0; n < 6; n++) step(0, 0, 0, 0, 0, 1);
    check("rst_mid_idle", io.out_valid, 0);
    one("after_rst", 32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0, 1, OVF_ON);
    for (int n = 0; n < 600; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
